alu_opnd_stage: RTL
===================

Name: alu_opnd_stage

Overview:
- Parametrised, registered successor of the combinational ALU operand select in the rvseed core.
- Sits between decode/regfile read and EX.
- Selects the ALU source pair from one of five modes and applies priority operand forwarding from N in-flight producers.
- Stalls on load-use (producer busy) hazards and holds the result in a one-entry valid/ready pipeline register with flush and a saturating stall counter.

Parameters:
- DATA_W, 32, datapath width (alu_src1/2, imm, pc, regfile data).
- FWD_N, 2, number of forwarding sources; index 0 = youngest = highest priority.
- RADDR_W, 5, register address width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  stage accepts this cycle.
- src_sel  in  3  0 REG, 1 IMM, 2 FOUR_PC, 3 PC_IMM, 4 ZERO_IMM; 5-7 reserved.
- rs1_addr, rs2_addr  in  RADDR_W each  source register indices.
- reg1_rdata, reg2_rdata  in  DATA_W each  regfile read data.
- imm  in  DATA_W  immediate.
- curr_pc  in  DATA_W  instruction pc.
- fwd_valid  in  FWD_N  producer entry i holds a register write.
- fwd_busy  in  FWD_N  producer i result not yet available (load in flight).
- fwd_addr  in  FWD_N*RADDR_W  producer i destination, packed, entry i at [i*RADDR_W +: RADDR_W].
- fwd_data  in  FWD_N*DATA_W  producer i result, packed likewise.
- flush  in  1  kill held entry and block capture.
- out_valid  out  1  registered operands valid.
- out_ready  in  1  EX consumes.
- alu_src1, alu_src2  out  DATA_W each  registered ALU operands.
- store_data  out  DATA_W  registered forwarded rs2 value.
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset: when rst_n is low at a clk edge, out_valid=0, alu_src1=alu_src2=store_data=0, stall_cnt=0.
- Forwarding, combinational:
  - op1 = fwd_data[i] for the lowest i with fwd_valid[i] && fwd_addr[i]==rs1_addr && rs1_addr!=0; otherwise reg1_rdata.
  - op2 is resolved the same way from rs2_addr and reg2_rdata.
  - Register 0 is never forwarded.
- Mode mapping (src1, src2):
  - REG: (op1, op2).
  - IMM: (op1, imm).
  - FOUR_PC: (4, curr_pc).
  - PC_IMM: (curr_pc, imm).
  - ZERO_IMM: (0, imm).
  - Reserved: behaves as REG.
  - store_data = op2 in all modes.
- Hazard:
  - Asserted when in_valid and the selected (lowest-index) match for rs1 or rs2 has fwd_busy set.
  - rs1 and rs2 are considered used only in REG and IMM modes (conservative; a load in IMM may stall spuriously).
  - A busy entry shadowed by a non-busy younger match does not cause a hazard.
- in_ready = rst_n && !flush && !hazard && (!out_valid || out_ready). It is combinational and may depend on in_valid only through hazard.
- Capture on in_valid && in_ready: operands and store_data register; out_valid<=1. Latency is 1 cycle from accept to out_valid.
- Drain: out_valid && out_ready with no capture gives out_valid<=0. Simultaneous drain and capture gives back-to-back throughput of 1 per cycle.
- Hold: out_valid && !out_ready keeps outputs stable and in_ready low.
- Flush: out_valid<=0 next edge; data registers may retain their values. Flush has priority over capture and drain. A flush in the same cycle as reset makes no difference.
- stall_cnt increments each cycle in_valid && hazard && !flush, saturates at all-ones, and never wraps.
- Reset mid-transaction drops the held entry with no handshake.
- Packed vectors: entry i at [i*W +: W].

Test Plan:
1. Reset, then REG with reg1=5, reg2=7, no forwarding -> next cycle out_valid=1, src1=5, src2=7, store_data=7.
2. FOUR_PC with curr_pc=0x100 -> src1=4, src2=0x100. PC_IMM with imm=0x20 -> (0x100, 0x20). ZERO_IMM with imm=0xABC00 -> (0, 0xABC00).
3. rs1=3; fwd entry0 (addr 3, data 0x11) and entry1 (addr 3, data 0x22) both valid -> src1=0x11. Same with rs1=0 -> src1=reg1_rdata.
4. IMM, rs1=4, entry0 valid/busy for addr 4 -> in_ready=0 for 3 cycles and stall_cnt=3. Drop busy -> accepted, src1=fwd_data[0].
5. out_ready=0 with a second instruction offered -> outputs stable, in_ready=0. Raise out_ready -> 1-per-cycle streaming of 4 instructions with no bubbles.
6. flush with out_valid=1 and in_valid=1 -> next cycle out_valid=0, nothing captured. stall_cnt preset near max with CNT_W=2 -> holds at 3.

Source files
------------

// File: rtl/alu_opnd_stage.sv
// ---------------------------------------------------------------------------
// alu_opnd_stage
//
// Purpose:
//   Registered ALU operand select between decode/regfile read and EX.
//   - Picks the ALU source pair from one of five modes.
//   - Resolves rs1/rs2 by priority forwarding from FWD_N in-flight producers.
//     Entry 0 is the youngest producer and wins over older entries.
//   - Stalls while a selected producer result is still busy (load-use).
//   - Holds the result in a one-entry valid/ready register with flush.
//   - Keeps a saturating count of hazard-stall cycles.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid / in_ready     decode handshake (in_ready is combinational)
//   src_sel[2:0]            0 REG, 1 IMM, 2 FOUR_PC, 3 PC_IMM, 4 ZERO_IMM;
//                           5-7 behave as REG
//   rs1_addr, rs2_addr      source register indices
//   reg1_rdata, reg2_rdata  regfile read data
//   imm, curr_pc            immediate and instruction pc
//   fwd_valid/busy[FWD_N]   producer holds a write / result not yet ready
//   fwd_addr, fwd_data      packed producer dest/result, entry i at [i*W +: W]
//   flush                   kill held entry and block capture
//   out_valid / out_ready   EX handshake
//   alu_src1, alu_src2      registered ALU operands
//   store_data              registered forwarded rs2 value
//   stall_cnt               saturating hazard-stall cycle count
// ---------------------------------------------------------------------------
module alu_opnd_stage #(
    parameter int DATA_W  = 32,
    parameter int FWD_N   = 2,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 src_sel,
    input  logic [RADDR_W-1:0]         rs1_addr,
    input  logic [RADDR_W-1:0]         rs2_addr,
    input  logic [DATA_W-1:0]          reg1_rdata,
    input  logic [DATA_W-1:0]          reg2_rdata,
    input  logic [DATA_W-1:0]          imm,
    input  logic [DATA_W-1:0]          curr_pc,
    input  logic [FWD_N-1:0]           fwd_valid,
    input  logic [FWD_N-1:0]           fwd_busy,
    input  logic [FWD_N*RADDR_W-1:0]   fwd_addr,
    input  logic [FWD_N*DATA_W-1:0]    fwd_data,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          alu_src1,
    output logic [DATA_W-1:0]          alu_src2,
    output logic [DATA_W-1:0]          store_data,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam logic [2:0] SEL_REG      = 3'd0;
    localparam logic [2:0] SEL_IMM      = 3'd1;
    localparam logic [2:0] SEL_FOUR_PC  = 3'd2;
    localparam logic [2:0] SEL_PC_IMM   = 3'd3;
    localparam logic [2:0] SEL_ZERO_IMM = 3'd4;

    // Saturating increment: sticks at all-ones, never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [DATA_W-1:0] w_op1_p0;
    logic [DATA_W-1:0] w_op2_p0;
    logic              w_busy1_p0;
    logic              w_busy2_p0;
    logic [DATA_W-1:0] w_src1_p0;
    logic [DATA_W-1:0] w_src2_p0;
    logic              w_uses_rs_p0;
    logic              w_hazard_p0;
    logic              w_capture_p0;

    logic              r_vld_p1;
    logic [DATA_W-1:0] r_src1_p1;
    logic [DATA_W-1:0] r_src2_p1;
    logic [DATA_W-1:0] r_store_p1;
    logic [CNT_W-1:0]  r_stall_cnt;

    // ---- stage p0: forwarding, mode select, hazard detect ----
    // Walk from oldest to youngest so the lowest matching index is written
    // last and wins. Register 0 never matches.
    always_comb begin
        w_op1_p0   = reg1_rdata;
        w_op2_p0   = reg2_rdata;
        w_busy1_p0 = 1'b0;
        w_busy2_p0 = 1'b0;
        for (int i = FWD_N - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_addr[i*RADDR_W +: RADDR_W] == rs1_addr) &&
                (rs1_addr != '0)) begin
                w_op1_p0   = fwd_data[i*DATA_W +: DATA_W];
                w_busy1_p0 = fwd_busy[i];
            end
            if (fwd_valid[i] && (fwd_addr[i*RADDR_W +: RADDR_W] == rs2_addr) &&
                (rs2_addr != '0)) begin
                w_op2_p0   = fwd_data[i*DATA_W +: DATA_W];
                w_busy2_p0 = fwd_busy[i];
            end
        end
    end

    always_comb begin
        w_src1_p0 = w_op1_p0;
        w_src2_p0 = w_op2_p0;
        case (src_sel)
            SEL_IMM: begin
                w_src1_p0 = w_op1_p0;
                w_src2_p0 = imm;
            end
            SEL_FOUR_PC: begin
                w_src1_p0 = DATA_W'(4);
                w_src2_p0 = curr_pc;
            end
            SEL_PC_IMM: begin
                w_src1_p0 = curr_pc;
                w_src2_p0 = imm;
            end
            SEL_ZERO_IMM: begin
                w_src1_p0 = '0;
                w_src2_p0 = imm;
            end
            default: begin
                w_src1_p0 = w_op1_p0;
                w_src2_p0 = w_op2_p0;
            end
        endcase
    end

    // Registers are treated as read in REG and IMM (IMM may be a store that
    // needs rs2). Reserved encodings act as REG, so they count as reading
    // registers too.
    assign w_uses_rs_p0 = (src_sel != SEL_FOUR_PC) && (src_sel != SEL_PC_IMM) &&
                          (src_sel != SEL_ZERO_IMM);
    assign w_hazard_p0  = in_valid && w_uses_rs_p0 && (w_busy1_p0 || w_busy2_p0);

    assign in_ready     = rst_n && !flush && !w_hazard_p0 && (!r_vld_p1 || out_ready);
    assign w_capture_p0 = in_valid && in_ready;

    // ---- stage p1: output register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_p1    <= 1'b0;
            r_src1_p1   <= '0;
            r_src2_p1   <= '0;
            r_store_p1  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (flush) begin
                r_vld_p1 <= 1'b0;
            end else if (w_capture_p0) begin
                r_vld_p1   <= 1'b1;
                r_src1_p1  <= w_src1_p0;
                r_src2_p1  <= w_src2_p0;
                r_store_p1 <= w_op2_p0;
            end else if (out_ready) begin
                r_vld_p1 <= 1'b0;
            end

            if (w_hazard_p0 && !flush) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
        end
    end

    assign out_valid  = r_vld_p1;
    assign alu_src1   = r_src1_p1;
    assign alu_src2   = r_src2_p1;
    assign store_data = r_store_p1;
    assign stall_cnt  = r_stall_cnt;

endmodule
